// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
//   Time-multiplexed driver for an NUM_DIGITS-digit seven-segment display.
//   Packed hex nibbles are captured into a pending register and copied into
//   the active (displayed) register only at frame boundaries, so a frame never
//   tears. Each digit slot starts with BLANK_CYCLES of dead time
//   (anti-ghosting). Optional leading-zero blanking is applied live. A
//   one-cycle frame strobe marks every frame boundary. All outputs are
//   registered: they show the internal state of the previous cycle.
//
//   Optional feature macro: SEG7_SCAN_BRIGHTNESS_PWM_EN
//     defined   -> adds i_brightness[3:0], sampled at each frame boundary.
//                  A free-running 4-bit pwm counter gates the ON phase
//                  (driven while pwm <= brightness: 0 -> 1/16, 15 -> full).
//     undefined -> no brightness port, full duty.
//
// Ports
//   i_clk         clock
//   i_reset       synchronous active-high reset
//   i_value_in    4*NUM_DIGITS hex nibbles, [3:0] = digit 0 (rightmost)
//   i_dp_in       decimal point per digit
//   i_load        capture i_value_in / i_dp_in into the pending registers
//   i_lz_blank    leading-zero blanking enable (live, not latched)
//   i_brightness  4-bit brightness (only with SEG7_SCAN_BRIGHTNESS_PWM_EN)
//   o_seg_out     segments {g,f,e,d,c,b,a}
//   o_dp_out      decimal point of the active digit
//   o_digit_sel   one-hot digit enable
//   o_frame_done  one-cycle pulse after each frame boundary
//   With COMMON_ANODE = 1, o_seg_out / o_dp_out / o_digit_sel are active-low.
// -----------------------------------------------------------------------------
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 10_000,
  parameter int BLANK_CYCLES = 16,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_value_in,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic                    i_load,
  input  logic                    i_lz_blank,
`ifdef SEG7_SCAN_BRIGHTNESS_PWM_EN
  input  logic [3:0]              i_brightness,
`endif
  output logic [6:0]              o_seg_out,
  output logic                    o_dp_out,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic                    o_frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // XOR masks turning active-high internal levels into pin polarity.
  localparam logic [6:0]            SEG_INV = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (COMMON_ANODE != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] SEL_INV = (COMMON_ANODE != 0) ? '1 : '0;

  // Hex nibble to {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_in_blank;
  logic                  w_pwm_on;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_lz_dark;
  logic [3:0]            w_nib;
  logic                  w_dp_bit;
  logic                  w_dark_bit;
  logic [NUM_DIGITS-1:0] w_sel_onehot;
  logic                  w_drive;
  logic [6:0]            w_seg_nxt;
  logic                  w_dp_nxt;
  logic [NUM_DIGITS-1:0] w_sel_nxt;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  // Dead time occupies the first BLANK_CYCLES counts of each slot.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
      assign w_in_blank = (r_cnt < BLANK_LIM);
    end
  endgenerate

`ifdef SEG7_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0] r_pwm;
  logic [3:0] r_bright;

  // Free-running pwm counter and brightness captured at frame boundaries.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pwm    <= 4'h0;
      r_bright <= 4'hF;
    end else begin
      r_pwm <= r_pwm + 4'h1;
      if (w_frame_end) begin
        r_bright <= i_brightness;
      end else begin
        r_bright <= r_bright;
      end
    end
  end

  assign w_pwm_on = (r_pwm <= r_bright);
`else
  assign w_pwm_on = 1'b1;
`endif

  // Leading-zero mask: walk down from the top digit while nibbles stay zero.
  always_comb begin
    w_zero_run = i_lz_blank;
    w_lz_dark  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_run   = w_zero_run && (r_act_val[4*k +: 4] == 4'h0);
      w_lz_dark[k] = w_zero_run;
    end
  end

  // Select nibble, decimal point and blanking flag of the scanned digit.
  always_comb begin
    w_nib        = 4'h0;
    w_dp_bit     = 1'b0;
    w_dark_bit   = 1'b0;
    w_sel_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib           = r_act_val[4*k +: 4];
        w_dp_bit        = r_act_dp[k];
        w_dark_bit      = w_lz_dark[k];
        w_sel_onehot[k] = 1'b1;
      end else begin
        w_sel_onehot[k] = 1'b0;
      end
    end
  end

  // Next pin levels; everything inactive unless the digit is really driven.
  always_comb begin
    w_drive = !w_in_blank && !w_dark_bit && w_pwm_on;
    if (w_drive) begin
      w_seg_nxt = seg7_decode(w_nib) ^ SEG_INV;
      w_dp_nxt  = w_dp_bit ^ DP_INV;
      w_sel_nxt = w_sel_onehot ^ SEL_INV;
    end else begin
      w_seg_nxt = SEG_INV;
      w_dp_nxt  = DP_INV;
      w_sel_nxt = SEL_INV;
    end
  end

  // Scan timing, pending/active value registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      o_seg_out    <= SEG_INV;
      o_dp_out     <= DP_INV;
      o_digit_sel  <= SEL_INV;
      o_frame_done <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_frame_end) begin
        r_idx <= '0;
      end else if (w_slot_end) begin
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_idx <= r_idx;
      end

      if (i_load) begin
        r_pend_val <= i_value_in;
        r_pend_dp  <= i_dp_in;
      end else begin
        r_pend_val <= r_pend_val;
        r_pend_dp  <= r_pend_dp;
      end

      // A load on the boundary cycle bypasses pending straight to active.
      if (w_frame_end) begin
        r_act_val <= i_load ? i_value_in : r_pend_val;
        r_act_dp  <= i_load ? i_dp_in    : r_pend_dp;
      end else begin
        r_act_val <= r_act_val;
        r_act_dp  <= r_act_dp;
      end

      o_seg_out    <= w_seg_nxt;
      o_dp_out     <= w_dp_nxt;
      o_digit_sel  <= w_sel_nxt;
      o_frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_mux
//   Self-checking bench for seg7_scan_mux (NUM_DIGITS=4, SCAN_DIV=8,
//   BLANK_CYCLES=2). A reference model derives the scan position purely from
//   the cycle count since reset and predicts every output cycle; a second
//   instance with COMMON_ANODE=1 is checked against the inverted prediction.
//   Directed scenarios pin literal values, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_seg7_scan_mux;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [15:0]   i_value_in = 16'h0000;
  logic [3:0]    i_dp_in = 4'h0;
  logic          i_load = 1'b0;
  logic          i_lz_blank = 1'b0;
`ifdef SEG7_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0]    i_brightness = 4'hF;
`endif
  logic [6:0]    o_seg_out, ca_seg_out;
  logic          o_dp_out, ca_dp_out;
  logic [3:0]    o_digit_sel, ca_digit_sel;
  logic          o_frame_done, ca_frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .COMMON_ANODE(0)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_value_in(i_value_in), .i_dp_in(i_dp_in),
    .i_load(i_load), .i_lz_blank(i_lz_blank),
`ifdef SEG7_SCAN_BRIGHTNESS_PWM_EN
    .i_brightness(i_brightness),
`endif
    .o_seg_out(o_seg_out), .o_dp_out(o_dp_out), .o_digit_sel(o_digit_sel),
    .o_frame_done(o_frame_done)
  );

  seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .COMMON_ANODE(1)) dut_ca (
    .i_clk(clk), .i_reset(i_reset), .i_value_in(i_value_in), .i_dp_in(i_dp_in),
    .i_load(i_load), .i_lz_blank(i_lz_blank),
`ifdef SEG7_SCAN_BRIGHTNESS_PWM_EN
    .i_brightness(i_brightness),
`endif
    .o_seg_out(ca_seg_out), .o_dp_out(ca_dp_out), .o_digit_sel(ca_digit_sel),
    .o_frame_done(ca_frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit         m_valid = 1'b0;
  int         m_n;
  logic [3:0] m_pend [ND];
  logic [3:0] m_act  [ND];
  logic [3:0] m_pdp, m_adp;
  int         m_bright;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [3:0] exp_sel;
  logic       exp_fd;

  initial begin
    forever begin
      @(posedge clk);
      if (i_reset) begin
        m_valid  = 1'b1;
        m_n      = 0;
        m_pdp    = 4'h0;
        m_adp    = 4'h0;
        m_bright = 15;
        for (int k = 0; k < ND; k++) begin
          m_pend[k] = 4'h0;
          m_act[k]  = 4'h0;
        end
        exp_seg = 7'h00; exp_dp = 1'b0; exp_sel = 4'h0; exp_fd = 1'b0;
      end else if (m_valid) begin
        int  cnt, idx;
        bit  on, dark, boundary;
        cnt  = m_n % SD;
        idx  = (m_n / SD) % ND;
        dark = 1'b0;
        if (i_lz_blank && idx != 0) begin
          dark = 1'b1;
          for (int k = idx; k < ND; k++) if (m_act[k] != 4'h0) dark = 1'b0;
        end
        on = (cnt >= BC) && !dark;
`ifdef SEG7_SCAN_BRIGHTNESS_PWM_EN
        if ((m_n % 16) > m_bright) on = 1'b0;
`endif
        exp_seg  = on ? seg_tab[m_act[idx]] : 7'h00;
        exp_dp   = on ? m_adp[idx] : 1'b0;
        exp_sel  = on ? (4'b0001 << idx) : 4'b0000;
        boundary = (m_n % FRAME) == (FRAME - 1);
        exp_fd   = boundary;
        if (i_load) begin
          for (int k = 0; k < ND; k++) m_pend[k] = i_value_in[4*k +: 4];
          m_pdp = i_dp_in;
        end
        if (boundary) begin
          for (int k = 0; k < ND; k++) m_act[k] = m_pend[k];
          m_adp = m_pdp;
`ifdef SEG7_SCAN_BRIGHTNESS_PWM_EN
          m_bright = int'(i_brightness);
`endif
        end
        m_n++;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("cycle_cmp", {19'd0, o_seg_out, o_dp_out, o_digit_sel, o_frame_done},
              {19'd0, exp_seg, exp_dp, exp_sel, exp_fd});
        check("cycle_cmp_ca", {19'd0, ca_seg_out, ca_dp_out, ca_digit_sel, ca_frame_done},
              {19'd0, ~exp_seg, ~exp_dp, ~exp_sel, exp_fd});
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [6:0] cap_seg [ND];
  logic [3:0] cap_sel [ND];

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (o_frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_wait_timeout", {31'd0, seen}, 32'd1);
  endtask

  // Called on the negedge showing frame_done: state offset 0 of a frame.
  // Digit k is sampled on the output of its slot count 4.
  task automatic capture_from_here();
    int pos = 0;
    for (int k = 0; k < ND; k++) begin
      repeat (8 * k + 5 - pos) @(negedge clk);
      pos = 8 * k + 5;
      cap_seg[k] = o_seg_out;
      cap_sel[k] = o_digit_sel;
    end
  endtask

  task automatic frame_capture();
    wait_frame();
    capture_from_here();
  endtask

  task automatic load_value(input logic [15:0] v);
    @(negedge clk);
    i_value_in = v;
    i_load     = 1'b1;
    @(negedge clk);
    i_load     = 1'b0;
  endtask

  // After the negedge showing reset values, check the restart sequence.
  task automatic check_restart(input string tag);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check({tag, "_sel"}, {28'd0, o_digit_sel}, (j >= 3 && j <= 8) ? 32'h1 : 32'h0);
      if (j == 3) check({tag, "_seg_zero"}, {25'd0, o_seg_out}, 32'h3F);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int period;
    bit seen;
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    // 1. reset held 3 clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg", {25'd0, o_seg_out}, 32'h00);
    check("rst_sel", {28'd0, o_digit_sel}, 32'h0);
    check("rst_dp", {31'd0, o_dp_out}, 32'h0);
    check("rst_fd", {31'd0, o_frame_done}, 32'h0);
    check("rst_ca_seg", {25'd0, ca_seg_out}, 32'h7F);
    check("rst_ca_sel", {28'd0, ca_digit_sel}, 32'hF);
    i_reset = 1'b0;
    check_restart("release");

    // 2. 12AF, no blanking
    load_value(16'h12AF);
    frame_capture();
    check("d0_F", {25'd0, cap_seg[0]}, 32'h71);
    check("d1_A", {25'd0, cap_seg[1]}, 32'h77);
    check("d2_2", {25'd0, cap_seg[2]}, 32'h5B);
    check("d3_1", {25'd0, cap_seg[3]}, 32'h06);
    check("d3_sel", {28'd0, cap_sel[3]}, 32'h8);
    wait_frame();
    period = 0;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      period++;
      if (o_frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_period", period, FRAME);

    // 3. leading-zero blanking
    i_lz_blank = 1'b1;
    load_value(16'h0050);
    frame_capture();
    check("lz50_d3_dark", {28'd0, cap_sel[3]}, 32'h0);
    check("lz50_d2_dark", {28'd0, cap_sel[2]}, 32'h0);
    check("lz50_d1", {25'd0, cap_seg[1]}, 32'h6D);
    check("lz50_d0", {25'd0, cap_seg[0]}, 32'h3F);
    load_value(16'h0000);
    frame_capture();
    check("lz0_d1_dark", {28'd0, cap_sel[1]}, 32'h0);
    check("lz0_d3_seg", {25'd0, cap_seg[3]}, 32'h00);
    check("lz0_d0", {25'd0, cap_seg[0]}, 32'h3F);
    check("lz0_d0_sel", {28'd0, cap_sel[0]}, 32'h1);

    // 4. no-tearing load rules
    i_lz_blank = 1'b0;
    load_value(16'h1111);
    frame_capture();
    check("d3_1111", {25'd0, cap_seg[3]}, 32'h06);
    wait_frame();
    repeat (18) @(negedge clk);
    i_value_in = 16'h2222;
    i_load     = 1'b1;
    @(negedge clk);
    i_load     = 1'b0;
    repeat (10) @(negedge clk);
    check("no_tear_d3", {25'd0, o_seg_out}, 32'h06);
    check("no_tear_d3_sel", {28'd0, o_digit_sel}, 32'h8);
    frame_capture();
    for (int k = 0; k < ND; k++) check("next_frame_2", {25'd0, cap_seg[k]}, 32'h5B);
    wait_frame();
    repeat (31) @(negedge clk);
    i_value_in = 16'h3333;
    i_load     = 1'b1;
    @(negedge clk);
    i_load     = 1'b0;
    check("bypass_fd", {31'd0, o_frame_done}, 32'h1);
    capture_from_here();
    for (int k = 0; k < ND; k++) check("bypass_3", {25'd0, cap_seg[k]}, 32'h4F);

    // 5. reset mid-ON on digit 2
    wait_frame();
    repeat (20) @(negedge clk);
    check("pre_rst_sel", {28'd0, o_digit_sel}, 32'h4);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("mid_rst_sel", {28'd0, o_digit_sel}, 32'h0);
    check("mid_rst_seg", {25'd0, o_seg_out}, 32'h00);
    check_restart("midrst");

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      i_load     = ($urandom_range(0, 7) == 0);
      i_value_in = 16'($urandom) & masks[$urandom_range(0, 4)];
      i_dp_in    = 4'($urandom);
      if ($urandom_range(0, 63) == 0) i_lz_blank = ~i_lz_blank;
      i_reset    = ($urandom_range(0, 599) == 0);
`ifdef SEG7_SCAN_BRIGHTNESS_PWM_EN
      i_brightness = 4'($urandom);
`endif
    end
    @(negedge clk);
    i_reset = 1'b0;
    i_load  = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
